i2s_slave_endpoint: RTL and testbench
=====================================

Name: i2s_slave_endpoint

Overview:
- I2S slave endpoint for the far end of the transceiver's I2S master link; sits on the host/SAI side of the bus.
- Takes BCLK and LRCLK as inputs and oversamples them with a single fast system clock.
- Deserialises the 24-bit RX I/Q stream arriving on sdin and serialises 16-bit TX I/Q back on sdout.
- Used as a bench/loopback partner and as the host-side bridge on boards without a hard SAI.

Parameters:
RX_WIDTH, 24, bits per received channel word, MSB first, left-justified in the slot
TX_WIDTH, 16, bits per transmitted channel word, MSB first, zero-padded to the slot end
MAX_SLOT, 63, bit count at which a slot with no LRCLK edge is declared overlong

Ports:
clk  in  1  system clock; must be at least 8x BCLK
_reset  in  1  asynchronous, active-low reset
bclk  in  1  I2S bit clock from the master, asynchronous to clk
lrclk  in  1  I2S word select; 0 = left/real (I), 1 = right/imag (Q)
sdin  in  1  serial data from the master (RX samples)
sdout  out  1  serial data to the master (TX samples)
rx_left  out  RX_WIDTH  last complete left/real word
rx_right  out  RX_WIDTH  last complete right/imag word
rx_valid  out  1  one-clk pulse when a new left+right pair is latched
tx_left  in  TX_WIDTH  left/real word to transmit
tx_right  in  TX_WIDTH  right/imag word to transmit
tx_ack  out  1  one-clk pulse when tx_left/tx_right have been captured
locked  out  1  high while frame-aligned (ACTIVE)
frame_err  out  1  one-clk pulse on a short or overlong slot

Behaviour:
- Reset state: all outputs 0, state SYNC_WAIT, shift registers and bit counter cleared.
- Input synchronisation:
  - bclk, lrclk and sdin each pass through a 2-FF synchroniser.
  - BCLK rise and fall are detected from the synchronised value and its previous value.
  - The pin-to-event latency is 3 clk.
- On every BCLK rise:
  - lrclk_s is sampled and compared with lrclk_prev.
  - If they differ, bitcnt <= 0 (the I2S one-bit delay slot); otherwise bitcnt <= bitcnt+1, saturating at MAX_SLOT.
- RX:
  - In ACTIVE, on a BCLK rise with bitcnt = k+1 (k = 0..RX_WIDTH-1), sdin_s is shifted in as data bit k (k = 0 is the MSB).
  - When bitcnt reaches RX_WIDTH, the shift register is copied to a pending register for the current channel.
  - Bits after RX_WIDTH are ignored.
- rx_valid:
  - rx_left and rx_right update together, one clk after the right word completes.
  - The update happens only if a left word completed earlier in the same frame.
  - rx_valid pulses in that same cycle.
- TX:
  - On a BCLK rise where LRCLK changes to 0, tx_left and tx_right are captured into holding registers and tx_ack pulses the next clk.
  - The slot shift register loads the held left word (new LRCLK = 0) or right word (new LRCLK = 1), zero-padded.
  - On each BCLK fall, sdout <= word bit bitcnt (bit 0 = MSB). This drives the MSB after the delay rise so the master samples it at bitcnt = 1.
  - sdout = 0 for bitcnt >= TX_WIDTH and whenever the block is not ACTIVE.
- State machine:
  - SYNC_WAIT -> ACTIVE on the first LRCLK 1->0 edge seen at a BCLK rise. locked rises on the same clk.
  - ACTIVE -> SYNC_WAIT on either error condition below; frame_err pulses and locked falls.
  - Error 1: an LRCLK edge while bitcnt < RX_WIDTH (short slot). The pending pair is discarded.
  - Error 2: bitcnt reaching MAX_SLOT (overlong slot or stopped LRCLK).
  - A short slot that ends on a 1->0 edge re-enters ACTIVE at that same edge. frame_err still pulses, but locked stays high in that case.
- Boundaries:
  - BCLK stopped: no events occur and outputs hold.
  - Reset mid-word: immediate return to the reset state; the partial word is lost.
  - tx_left/tx_right changing outside the capture edge has no effect on the current frame.
  - Simultaneous rx_valid and tx_ack are both asserted (independent).

Test Plan:
- Master sends 32-bit slots with L = 24'hA5C3F0 and R = 24'h123456 after a 1->0 LRCLK edge -> locked = 1; rx_valid pulses once per frame with rx_left = A5C3F0 and rx_right = 123456.
- tx_left = 16'h8001, tx_right = 16'h7FFE -> master captures L = 8001 and R = 7FFE, each followed by 16 zero bits; tx_ack pulses once per frame.
- Reset asserted mid-left-slot, then released -> all outputs 0; no rx_valid until after the next 1->0 LRCLK edge plus one full L+R frame.
- Inject a 16-bit slot (LRCLK toggles at bitcnt = 16) -> frame_err pulses; no rx_valid for that frame; correct data resumes on the next good frame.
- Hold LRCLK constant for 64 BCLKs -> frame_err pulses at bitcnt = 63; locked = 0; sdout = 0.
- BCLK = clk/8 with random phase jitter of ±1 clk -> bit-exact loopback of 1000 random pairs.

Source files
------------

// File: rtl/i2s_slave_endpoint.sv
// I2S slave endpoint: oversamples BCLK/LRCLK on clk, deserialises RX_WIDTH-bit L/R words
// from sdin and serialises TX_WIDTH-bit L/R words onto sdout, with frame-alignment tracking.
module i2s_slave_endpoint #(
    parameter int RX_WIDTH = 24,
    parameter int TX_WIDTH = 16,
    parameter int MAX_SLOT = 63
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                bclk,
    input  logic                lrclk,
    input  logic                sdin,
    output logic                sdout,
    output logic [RX_WIDTH-1:0] rx_left,
    output logic [RX_WIDTH-1:0] rx_right,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_left,
    input  logic [TX_WIDTH-1:0] tx_right,
    output logic                tx_ack,
    output logic                locked,
    output logic                frame_err
);
    localparam int CW = $clog2(MAX_SLOT + 1);
    localparam logic [CW-1:0] RX_CNT  = CW'(RX_WIDTH);
    localparam logic [CW-1:0] TX_CNT  = CW'(TX_WIDTH);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SLOT);

    typedef enum logic {SYNC_WAIT, ACTIVE} state_t;

    // NOTE: bclk, lrclk and sdin share one 2-FF synchroniser depth, so their relative timing survives.
    logic [2:0]          meta_q, meta_d, sync_q, sync_d;
    logic                bclk_prev_q, bclk_prev_d;
    logic                lrclk_prev_q, lrclk_prev_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    state_t              state_q, state_d;
    logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [RX_WIDTH-1:0] pend_left_q, pend_left_d, pend_right_q, pend_right_d;
    logic                left_done_q, left_done_d, commit_q, commit_d;
    logic [RX_WIDTH-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
    logic                rx_valid_q, rx_valid_d;
    logic [TX_WIDTH-1:0] tx_hold_right_q, tx_hold_right_d, tx_slot_q, tx_slot_d;
    logic                tx_ack_q, tx_ack_d, sdout_q, sdout_d;
    logic                locked_q, locked_d, frame_err_q, frame_err_d;

    logic          bclk_s, lrclk_s, sdin_s, bclk_rise, bclk_fall, lr_edge;
    logic [CW-1:0] cnt_inc;

    assign bclk_s    = sync_q[2];
    assign lrclk_s   = sync_q[1];
    assign sdin_s    = sync_q[0];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign bclk_fall = ~bclk_s & bclk_prev_q;
    assign lr_edge   = lrclk_s ^ lrclk_prev_q;
    assign cnt_inc   = (bitcnt_q == MAX_CNT) ? MAX_CNT : bitcnt_q + 1'b1;

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path leaves a latch behind.
        meta_d          = {bclk, lrclk, sdin};
        sync_d          = meta_q;
        bclk_prev_d     = bclk_s;
        lrclk_prev_d    = lrclk_prev_q;
        bitcnt_d        = bitcnt_q;
        state_d         = state_q;
        rx_shift_d      = rx_shift_q;
        pend_left_d     = pend_left_q;
        pend_right_d    = pend_right_q;
        left_done_d     = left_done_q;
        commit_d        = 1'b0;
        rx_left_d       = rx_left_q;
        rx_right_d      = rx_right_q;
        rx_valid_d      = 1'b0;
        tx_hold_right_d = tx_hold_right_q;
        tx_slot_d       = tx_slot_q;
        tx_ack_d        = 1'b0;
        sdout_d         = sdout_q;
        frame_err_d     = 1'b0;

        if (commit_q) begin
            rx_left_d  = pend_left_q;
            rx_right_d = pend_right_q;
            rx_valid_d = 1'b1;
        end

        if (bclk_rise) begin
            lrclk_prev_d = lrclk_s;
            if (lr_edge) begin
                bitcnt_d = '0;
                if (!lrclk_s) begin
                    // Frame start: the whole TX pair is sampled here and nowhere else.
                    tx_hold_right_d = tx_right;
                    tx_slot_d       = tx_left;
                    tx_ack_d        = 1'b1;
                    left_done_d     = 1'b0;
                end else begin
                    tx_slot_d = tx_hold_right_q;
                end
                if (state_q == ACTIVE && bitcnt_q < RX_CNT) begin
                    frame_err_d = 1'b1;
                    left_done_d = 1'b0;
                    state_d     = lrclk_s ? SYNC_WAIT : ACTIVE;
                end else if (state_q == SYNC_WAIT && !lrclk_s) begin
                    state_d = ACTIVE;
                end
            end else begin
                bitcnt_d = cnt_inc;
                if (state_q == ACTIVE) begin
                    if (cnt_inc <= RX_CNT) begin
                        rx_shift_d = {rx_shift_q[RX_WIDTH-2:0], sdin_s};
                        if (cnt_inc == RX_CNT && !lrclk_s) begin
                            pend_left_d = rx_shift_d;
                            left_done_d = 1'b1;
                        end else if (cnt_inc == RX_CNT) begin
                            pend_right_d = rx_shift_d;
                            commit_d     = left_done_q;
                            left_done_d  = 1'b0;
                        end
                    end
                    if (cnt_inc == MAX_CNT) begin
                        frame_err_d = 1'b1;
                        left_done_d = 1'b0;
                        state_d     = SYNC_WAIT;
                    end
                end
            end
        end

        if (bclk_fall) begin
            if (state_q == ACTIVE && bitcnt_q < TX_CNT) begin
                sdout_d   = tx_slot_q[TX_WIDTH-1];
                tx_slot_d = {tx_slot_q[TX_WIDTH-2:0], 1'b0};
            end else begin
                sdout_d = 1'b0;
            end
        end
        if (state_d != ACTIVE) begin
            sdout_d = 1'b0;
        end
        locked_d = (state_d == ACTIVE);
    end

    // NOTE: state updates use non-blocking assignments only; all logic lives in the always_comb above.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            meta_q          <= '0;
            sync_q          <= '0;
            bclk_prev_q     <= 1'b0;
            lrclk_prev_q    <= 1'b0;
            bitcnt_q        <= '0;
            state_q         <= SYNC_WAIT;
            rx_shift_q      <= '0;
            pend_left_q     <= '0;
            pend_right_q    <= '0;
            left_done_q     <= 1'b0;
            commit_q        <= 1'b0;
            rx_left_q       <= '0;
            rx_right_q      <= '0;
            rx_valid_q      <= 1'b0;
            tx_hold_right_q <= '0;
            tx_slot_q       <= '0;
            tx_ack_q        <= 1'b0;
            sdout_q         <= 1'b0;
            locked_q        <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            meta_q          <= meta_d;
            sync_q          <= sync_d;
            bclk_prev_q     <= bclk_prev_d;
            lrclk_prev_q    <= lrclk_prev_d;
            bitcnt_q        <= bitcnt_d;
            state_q         <= state_d;
            rx_shift_q      <= rx_shift_d;
            pend_left_q     <= pend_left_d;
            pend_right_q    <= pend_right_d;
            left_done_q     <= left_done_d;
            commit_q        <= commit_d;
            rx_left_q       <= rx_left_d;
            rx_right_q      <= rx_right_d;
            rx_valid_q      <= rx_valid_d;
            tx_hold_right_q <= tx_hold_right_d;
            tx_slot_q       <= tx_slot_d;
            tx_ack_q        <= tx_ack_d;
            sdout_q         <= sdout_d;
            locked_q        <= locked_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign sdout     = sdout_q;
    assign rx_left   = rx_left_q;
    assign rx_right  = rx_right_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ack    = tx_ack_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_slave_endpoint.sv
// Directed bench for i2s_slave_endpoint: the bench acts as I2S master (drives BCLK/LRCLK/sdin,
// samples sdout at each BCLK rise) and compares received words and pulse counts with hand values.
module tb_i2s_slave_endpoint;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk = 1'b0, lrclk = 1'b0, sdin = 1'b0;
    logic        sdout, rx_valid, tx_ack, locked, frame_err;
    logic [23:0] rx_left, rx_right;
    logic [15:0] tx_left = 16'h8001, tx_right = 16'h7FFE;

    int n_checks = 0, n_fail = 0;
    int rxv_cnt = 0, ack_cnt = 0, ferr_cnt = 0, lock_drop = 0;
    logic locked_prev = 1'b0;

    i2s_slave_endpoint dut (
        .clk(clk), ._reset(rst_n), .bclk(bclk), .lrclk(lrclk), .sdin(sdin), .sdout(sdout),
        .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
        .tx_left(tx_left), .tx_right(tx_right), .tx_ack(tx_ack),
        .locked(locked), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  rxv_cnt++;
        if (tx_ack)    ack_cnt++;
        if (frame_err) ferr_cnt++;
        if (locked_prev && !locked) lock_drop++;
        locked_prev = locked;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_left"},   32'(rx_left),   32'h0);
        check({tag, "_rx_right"},  32'(rx_right),  32'h0);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
        check({tag, "_tx_ack"},    32'(tx_ack),    32'h0);
        check({tag, "_locked"},    32'(locked),    32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_sdout"},     32'(sdout),     32'h0);
    endtask

    // One BCLK period: fall (drive lr/d), wait, sample sdout, rise, wait.
    task automatic bclk_cycle(input logic lr, input logic d, input bit jit, output logic so);
        int h;
        bclk = 1'b0; lrclk = lr; sdin = d;
        h = jit ? int'($urandom_range(5, 3)) : 4;
        repeat (h) @(negedge clk);
        so = sdout;
        bclk = 1'b1;
        h = jit ? int'($urandom_range(5, 3)) : 4;
        repeat (h) @(negedge clk);
    endtask

    task automatic send_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                              input int nl, input int nr, input int exp_rxv, input int exp_ferr,
                              input bit chk_tx, input bit jit, input int rst_pos,
                              input logic [15:0] tl_new, input logic [15:0] tr_new);
        logic [15:0] exp_tl, exp_tr, got_l, got_r;
        logic [23:0] w;
        logic        so, d;
        bit          pad_ok;
        int          rxv0, ack0, ferr0, n;
        exp_tl = tx_left; exp_tr = tx_right;
        rxv0 = rxv_cnt; ack0 = ack_cnt; ferr0 = ferr_cnt;
        got_l = '0; got_r = '0; pad_ok = 1'b1;
        for (int s = 0; s < 2; s++) begin
            n = (s == 1) ? nr : nl;
            w = (s == 1) ? r : l;
            for (int j = 0; j < n; j++) begin
                d = (j >= 1 && j <= 24) ? w[24-j] : 1'b0;
                bclk_cycle(s == 1, d, jit, so);
                if (j >= 1 && j <= 16) begin
                    if (s == 0) got_l[16-j] = so;
                    else        got_r[16-j] = so;
                end else if (j > 16 && so !== 1'b0) begin
                    pad_ok = 1'b0;
                end
                if (s == 0 && j == 5) begin
                    tx_left = tl_new; tx_right = tr_new;
                end
                if (s == 0 && j == rst_pos) begin
                    @(negedge clk); rst_n = 1'b0;
                    @(negedge clk);
                    check_reset_state({tag, "_rst"});
                    repeat (2) @(negedge clk); rst_n = 1'b1;
                end
            end
        end
        check({tag, "_rxv_cnt"},  32'(rxv_cnt - rxv0),   32'(exp_rxv));
        check({tag, "_ferr_cnt"}, 32'(ferr_cnt - ferr0), 32'(exp_ferr));
        check({tag, "_ack_cnt"},  32'(ack_cnt - ack0),   32'd1);
        if (exp_rxv != 0) begin
            check({tag, "_rx_left"},  32'(rx_left),  32'(l));
            check({tag, "_rx_right"}, 32'(rx_right), 32'(r));
        end
        if (chk_tx) begin
            check({tag, "_tx_l"}, 32'(got_l), 32'(exp_tl));
            check({tag, "_tx_r"}, 32'(got_r), 32'(exp_tr));
            check({tag, "_tx_pad"}, 32'(pad_ok), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        so;
        logic [23:0] rl, rr;
        logic [15:0] tl, tr;
        int          drops0, rxv0, ferr0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) bclk_cycle(1'b1, 1'b0, 1'b0, so);
        check("prelock_locked", 32'(locked), 32'h0);

        send_frame("f1", 24'hA5C3F0, 24'h123456, 32, 32, 1, 0, 1, 0, -1, 16'h8001, 16'h7FFE);
        check("f1_locked", 32'(locked), 32'h1);
        // tx inputs change mid-frame; the frame in flight keeps 8001/7FFE.
        send_frame("f2", 24'hA5C3F0, 24'h123456, 32, 32, 1, 0, 1, 0, -1, 16'h1234, 16'hABCD);
        send_frame("f3", 24'hFFFFFF, 24'h000001, 32, 32, 1, 0, 1, 0, -1, 16'h0000, 16'hFFFF);
        send_frame("f4_rst", 24'h3C3C3C, 24'hC3C3C3, 32, 32, 0, 0, 0, 0, 10, 16'h0000, 16'hFFFF);
        check("f4_locked", 32'(locked), 32'h0);
        check("f4_rx_left", 32'(rx_left), 32'h0);
        send_frame("f5", 24'h5A5A5A, 24'hA5A5A5, 32, 32, 1, 0, 1, 0, -1, 16'h0F0F, 16'hF0F0);
        send_frame("f6_short_l", 24'h111111, 24'h222222, 16, 32, 0, 1, 0, 0, -1, 16'h0F0F, 16'hF0F0);
        check("f6_locked", 32'(locked), 32'h0);
        send_frame("f7", 24'h800000, 24'h7FFFFF, 32, 32, 1, 0, 1, 0, -1, 16'hC001, 16'h3FFE);
        drops0 = lock_drop;
        send_frame("f8_short_r", 24'h333333, 24'h444444, 32, 16, 0, 0, 0, 0, -1, 16'hC001, 16'h3FFE);
        send_frame("f9", 24'hDEADBE, 24'hEF0123, 32, 32, 1, 1, 1, 0, -1, 16'h5555, 16'hAAAA);
        check("f9_lock_kept", 32'(lock_drop - drops0), 32'h0);
        send_frame("f10_long", 24'h0, 24'h0, 70, 32, 0, 1, 0, 0, -1, 16'h5555, 16'hAAAA);
        check("f10_locked", 32'(locked), 32'h0);
        check("f10_sdout", 32'(sdout), 32'h0);
        send_frame("f11", 24'h6789AB, 24'hCDEF01, 32, 32, 1, 0, 1, 0, -1, 16'h5555, 16'hAAAA);

        for (int i = 0; i < 30; i++) begin
            rl = 24'($urandom); rr = 24'($urandom);
            tl = 16'($urandom); tr = 16'($urandom);
            send_frame($sformatf("jit%0d", i), rl, rr, 32, 32, 1, 0, 1, 1, -1, tl, tr);
        end

        // BCLK stopped: nothing moves.
        rxv0 = rxv_cnt; ferr0 = ferr_cnt;
        repeat (100) @(negedge clk);
        check("idle_rxv", 32'(rxv_cnt - rxv0), 32'h0);
        check("idle_ferr", 32'(ferr_cnt - ferr0), 32'h0);
        check("idle_locked", 32'(locked), 32'h1);
        check("idle_rx_left", 32'(rx_left), 32'(rl));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
